// File: rtl/usb_fs_rx_phy.sv
// Full-speed USB receive front end: synchronizer, 4x oversampling DPLL, SYNC detect,
// NRZI decode, bit unstuffing and EOP detection. Optional bus-reset detect: USB_FS_RX_BUS_RESET_DET_EN.
module usb_fs_rx_phy #(
  parameter int unsigned SYNC_MIN_TRANS   = 5,
  parameter int unsigned STUFF_LIMIT      = 6,
  parameter int unsigned BUS_RESET_CYCLES = 120
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  output logic [1:0] line_state,
  output logic       pkt_start,
  output logic       bit_strobe,
  output logic       bit_data,
  output logic       pkt_end,
  output logic       rx_err,
  output logic       rx_active,
  output logic       bus_reset
);

  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;
  localparam logic [1:0] LS_SE1 = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ABORT} state_e;

  logic       p_meta_q, p_sync_q, n_meta_q, n_sync_q;
  logic [1:0] ls_q, ls_prev_q, samp_prev_q;
  logic [1:0] phase_q;
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] stuff_q, stuff_d;
  logic       start_q, start_d, strobe_q, strobe_d, data_q, data_d;
  logic       end_q, end_d, err_q, err_d;
  logic       sample_pt, nrzi_one, bus_rst;

  assign sample_pt = (phase_q == 2'd1);
  assign nrzi_one  = (ls_q == samp_prev_q);

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      p_meta_q    <= 1'b1;
      p_sync_q    <= 1'b1;
      n_meta_q    <= 1'b0;
      n_sync_q    <= 1'b0;
      ls_q        <= LS_J;
      ls_prev_q   <= LS_J;
      samp_prev_q <= LS_J;
      phase_q     <= '0;
    end else begin
      p_meta_q  <= usb_p_rx;
      p_sync_q  <= p_meta_q;
      n_meta_q  <= usb_n_rx;
      n_sync_q  <= n_meta_q;
      // {D-, D+} maps directly onto the SE0/J/K/SE1 encoding
      ls_q      <= {n_sync_q, p_sync_q};
      ls_prev_q <= ls_q;
      phase_q   <= (ls_q != ls_prev_q) ? 2'd0 : phase_q + 2'd1;
      if (sample_pt) samp_prev_q <= ls_q;
    end
  end

`ifdef USB_FS_RX_BUS_RESET_DET_EN
  logic [7:0] se0_run_q, se0_run_d;
  logic       bus_reset_q, bus_reset_d;

  always_comb begin
    se0_run_d   = '0;
    bus_reset_d = 1'b0;
    if (ls_q == LS_SE0) begin
      se0_run_d   = (se0_run_q == 8'hFF) ? se0_run_q : se0_run_q + 8'd1;
      bus_reset_d = bus_reset_q | (se0_run_d >= 8'(BUS_RESET_CYCLES));
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      se0_run_q   <= '0;
      bus_reset_q <= 1'b0;
    end else begin
      se0_run_q   <= se0_run_d;
      bus_reset_q <= bus_reset_d;
    end
  end

  assign bus_rst = bus_reset_q;
`else
  assign bus_rst = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stuff_d  = stuff_q;
    start_d  = 1'b0;
    strobe_d = 1'b0;
    data_d   = data_q;
    end_d    = 1'b0;
    err_d    = 1'b0;
    if (bus_rst) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      stuff_d = '0;
    end else if (sample_pt) begin
      unique case (state_q)
        S_IDLE: if (ls_q == LS_K) begin
          state_d = S_SYNC;
          cnt_d   = 3'd1;
        end
        S_SYNC: begin
          if (ls_q == LS_SE0 || ls_q == LS_SE1) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (ls_q != samp_prev_q) begin
            cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
          end else if (ls_q == LS_K && cnt_q >= 3'(SYNC_MIN_TRANS)) begin
            state_d = S_DATA;
            start_d = 1'b1;
            stuff_d = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          if (ls_q == LS_SE0) begin
            state_d = S_EOP;
            cnt_d   = 3'd1;
          end else if (ls_q == LS_SE1) begin
            state_d = S_ABORT;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else if (stuff_q == 3'(STUFF_LIMIT)) begin
            stuff_d = '0;
            if (nrzi_one) begin
              state_d = S_ABORT;
              err_d   = 1'b1;
              cnt_d   = '0;
            end
          end else begin
            strobe_d = 1'b1;
            data_d   = nrzi_one;
            stuff_d  = nrzi_one ? stuff_q + 3'd1 : 3'd0;
          end
        end
        S_EOP: begin
          if (ls_q == LS_SE0) begin
`ifdef USB_FS_RX_BUS_RESET_DET_EN
            // long SE0 may be a bus reset in progress: hold off and let the detector decide
            if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
`else
            if (cnt_q == 3'd3) begin
              state_d = S_ABORT;
              err_d   = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
`endif
          end else if (ls_q == LS_J && cnt_q >= 3'd2 && cnt_q <= 3'd3) begin
            state_d = S_IDLE;
            end_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_ABORT;
            err_d   = 1'b1;
            cnt_d   = '0;
          end
        end
        S_ABORT: begin
          if (ls_q == LS_J) begin
            if (cnt_q != 3'd0) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = 3'd1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      stuff_q  <= '0;
      start_q  <= 1'b0;
      strobe_q <= 1'b0;
      data_q   <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stuff_q  <= stuff_d;
      start_q  <= start_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      end_q    <= end_d;
      err_q    <= err_d;
    end
  end

  assign line_state = ls_q;
  assign pkt_start  = start_q;
  assign bit_strobe = strobe_q;
  assign bit_data   = data_q;
  assign pkt_end    = end_q;
  assign rx_err     = err_q;
  assign rx_active  = (state_q == S_DATA || state_q == S_EOP) && !bus_rst;
  assign bus_reset  = bus_rst;

endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// Directed self-checking bench for usb_fs_rx_phy; bus-reset scenario runs only with
// USB_FS_RX_BUS_RESET_DET_EN defined.
module tb_usb_fs_rx_phy;

  localparam logic [1:0] SE0 = 2'd0;
  localparam logic [1:0] LJ  = 2'd1;
  localparam logic [1:0] LK  = 2'd2;

  logic       clk_48mhz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       usb_p_rx  = 1'b1;
  logic       usb_n_rx  = 1'b0;
  logic [1:0] line_state;
  logic       pkt_start, bit_strobe, bit_data, pkt_end, rx_err, rx_active, bus_reset;

  int n_chk  = 0;
  int n_fail = 0;

  int c_start = 0, c_strobe = 0, c_end = 0, c_err = 0, c_err_act = 0, c_multi = 0;
  int cyc = 0, last_strobe = 0, min_gap = 1000;
  logic bitbuf [0:1023];

  usb_fs_rx_phy #(
    .SYNC_MIN_TRANS(5),
    .STUFF_LIMIT(6),
    .BUS_RESET_CYCLES(120)
  ) dut (
    .clk_48mhz (clk_48mhz),
    .reset_n   (reset_n),
    .usb_p_rx  (usb_p_rx),
    .usb_n_rx  (usb_n_rx),
    .line_state(line_state),
    .pkt_start (pkt_start),
    .bit_strobe(bit_strobe),
    .bit_data  (bit_data),
    .pkt_end   (pkt_end),
    .rx_err    (rx_err),
    .rx_active (rx_active),
    .bus_reset (bus_reset)
  );

  always #10 clk_48mhz = ~clk_48mhz;

  always @(posedge clk_48mhz) cyc++;

  always @(negedge clk_48mhz) begin
    if ((int'(pkt_start) + int'(bit_strobe) + int'(pkt_end) + int'(rx_err)) > 1) c_multi++;
    if (pkt_start) c_start++;
    if (pkt_end) c_end++;
    if (rx_err) begin
      c_err++;
      if (rx_active) c_err_act++;
    end
    if (bit_strobe) begin
      bitbuf[c_strobe % 1024] = bit_data;
      if (c_strobe > 0 && (cyc - last_strobe) < min_gap) min_gap = cyc - last_strobe;
      last_strobe = cyc;
      c_strobe++;
    end
  end

  // Pads are always changed on a falling edge; the symbol is held n cycles.
  task automatic sym(input logic [1:0] s, input int n);
    {usb_n_rx, usb_p_rx} = s;
    repeat (n) @(negedge clk_48mhz);
  endtask

  task automatic send_sync();
    sym(LK, 4); sym(LJ, 4); sym(LK, 4); sym(LJ, 4);
    sym(LK, 4); sym(LJ, 4); sym(LK, 4); sym(LK, 4);
  endtask

  // NRZI: a 0 toggles the level, a 1 holds it; jitter alternates 3/5-cycle cells.
  task automatic send_data(input logic [15:0] bits, input int n, input bit jitter);
    logic [1:0] lvl;
    lvl = LK;
    for (int i = 0; i < n; i++) begin
      if (!bits[i]) lvl = (lvl == LK) ? LJ : LK;
      sym(lvl, jitter ? ((i % 2 == 0) ? 3 : 5) : 4);
    end
  endtask

  task automatic send_eop();
    sym(SE0, 8);
    sym(LJ, 4);
    sym(LJ, 16);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    n_chk++;
    if ({line_state, pkt_start, bit_strobe, bit_data, pkt_end, rx_err, rx_active, bus_reset} !== 9'b01_0000000) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected %b",
               {line_state, pkt_start, bit_strobe, bit_data, pkt_end, rx_err, rx_active, bus_reset}, 9'b01_0000000);
    end
    reset_n = 1'b1;
    sym(LJ, 16);
  endtask

  task automatic test_latency();
    {usb_n_rx, usb_p_rx} = LK;
    repeat (2) @(posedge clk_48mhz);
    #1;
    n_chk++;
    if (line_state !== LJ) begin
      n_fail++;
      $display("FAIL latency_early: line_state %0d expected %0d", line_state, LJ);
    end
    @(posedge clk_48mhz);
    #1;
    n_chk++;
    if (line_state !== LK) begin
      n_fail++;
      $display("FAIL latency_3cyc: line_state %0d expected %0d", line_state, LK);
    end
    @(negedge clk_48mhz);
    sym(LK, 1);
    sym(LJ, 32);
  endtask

  task automatic test_byte_a5();
    int s0, st0, e0, r0;
    logic [15:0] exp;
    s0 = c_start; st0 = c_strobe; e0 = c_end; r0 = c_err;
    exp = 16'h00A5;
    send_sync();
    send_data(16'h00A5, 8, 1'b0);
    send_eop();
    n_chk++;
    if (c_start - s0 !== 1) begin n_fail++; $display("FAIL a5_pkt_start: count %0d expected 1", c_start - s0); end
    n_chk++;
    if (c_strobe - st0 !== 8) begin n_fail++; $display("FAIL a5_strobes: count %0d expected 8", c_strobe - st0); end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (bitbuf[(st0 + i) % 1024] !== exp[i]) begin
        n_fail++;
        $display("FAIL a5_bit%0d: got %b expected %b", i, bitbuf[(st0 + i) % 1024], exp[i]);
      end
    end
    n_chk++;
    if (c_end - e0 !== 1) begin n_fail++; $display("FAIL a5_pkt_end: count %0d expected 1", c_end - e0); end
    n_chk++;
    if (c_err - r0 !== 0) begin n_fail++; $display("FAIL a5_rx_err: count %0d expected 0", c_err - r0); end
    n_chk++;
    if (rx_active !== 1'b0) begin n_fail++; $display("FAIL a5_rx_active_after: got %b expected 0", rx_active); end
  endtask

  task automatic test_unstuff();
    int st0, r0, e0;
    st0 = c_strobe; r0 = c_err; e0 = c_end;
    send_sync();
    send_data(16'h01BF, 9, 1'b0);
    send_eop();
    n_chk++;
    if (c_strobe - st0 !== 8) begin n_fail++; $display("FAIL unstuff_strobes: count %0d expected 8", c_strobe - st0); end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (bitbuf[(st0 + i) % 1024] !== 1'b1) begin
        n_fail++;
        $display("FAIL unstuff_bit%0d: got %b expected 1", i, bitbuf[(st0 + i) % 1024]);
      end
    end
    n_chk++;
    if (c_err - r0 !== 0 || c_end - e0 !== 1) begin
      n_fail++;
      $display("FAIL unstuff_framing: err %0d end %0d expected 0 and 1", c_err - r0, c_end - e0);
    end
  endtask

  task automatic test_stuff_err();
    int st0, r0, e0, a0, s0;
    logic [15:0] exp;
    st0 = c_strobe; r0 = c_err; e0 = c_end; a0 = c_err_act;
    send_sync();
    send_data(16'h007F, 7, 1'b0);
    sym(LJ, 16);
    n_chk++;
    if (c_err - r0 !== 1) begin n_fail++; $display("FAIL stufferr_rx_err: count %0d expected 1", c_err - r0); end
    n_chk++;
    if (c_strobe - st0 !== 6) begin n_fail++; $display("FAIL stufferr_strobes: count %0d expected 6", c_strobe - st0); end
    n_chk++;
    if (c_err_act - a0 !== 0 || rx_active !== 1'b0) begin
      n_fail++;
      $display("FAIL stufferr_rx_active: active-at-err %0d now %b expected 0 and 0", c_err_act - a0, rx_active);
    end
    n_chk++;
    if (c_end - e0 !== 0) begin n_fail++; $display("FAIL stufferr_pkt_end: count %0d expected 0", c_end - e0); end
    // the following packet must be received cleanly
    s0 = c_start; st0 = c_strobe; r0 = c_err; e0 = c_end;
    exp = 16'h00A5;
    send_sync();
    send_data(16'h00A5, 8, 1'b0);
    send_eop();
    n_chk++;
    if (c_start - s0 !== 1 || c_end - e0 !== 1 || c_err - r0 !== 0 || c_strobe - st0 !== 8) begin
      n_fail++;
      $display("FAIL stufferr_recover: start %0d end %0d err %0d strobes %0d expected 1 1 0 8",
               c_start - s0, c_end - e0, c_err - r0, c_strobe - st0);
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (bitbuf[(st0 + i) % 1024] !== exp[i]) begin
        n_fail++;
        $display("FAIL recover_bit%0d: got %b expected %b", i, bitbuf[(st0 + i) % 1024], exp[i]);
      end
    end
  endtask

  task automatic test_jitter();
    int st0, e0, r0;
    logic [15:0] exp;
    st0 = c_strobe; e0 = c_end; r0 = c_err;
    exp = 16'h003C;
    send_sync();
    send_data(16'h003C, 8, 1'b1);
    send_eop();
    n_chk++;
    if (c_strobe - st0 !== 8) begin n_fail++; $display("FAIL jitter_strobes: count %0d expected 8", c_strobe - st0); end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (bitbuf[(st0 + i) % 1024] !== exp[i]) begin
        n_fail++;
        $display("FAIL jitter_bit%0d: got %b expected %b", i, bitbuf[(st0 + i) % 1024], exp[i]);
      end
    end
    n_chk++;
    if (c_end - e0 !== 1 || c_err - r0 !== 0) begin
      n_fail++;
      $display("FAIL jitter_framing: end %0d err %0d expected 1 and 0", c_end - e0, c_err - r0);
    end
  endtask

  task automatic test_short_sync();
    int s0, st0, r0;
    s0 = c_start; st0 = c_strobe; r0 = c_err;
    sym(LK, 4); sym(LJ, 4); sym(LK, 4); sym(LK, 4); sym(LK, 4);
    sym(LJ, 32);
    n_chk++;
    if (c_start - s0 !== 0) begin n_fail++; $display("FAIL shortsync_pkt_start: count %0d expected 0", c_start - s0); end
    n_chk++;
    if (c_strobe - st0 !== 0 || c_err - r0 !== 0) begin
      n_fail++;
      $display("FAIL shortsync_quiet: strobes %0d err %0d expected 0 and 0", c_strobe - st0, c_err - r0);
    end
    s0 = c_start;
    send_sync();
    send_data(16'h00A5, 8, 1'b0);
    send_eop();
    n_chk++;
    if (c_start - s0 !== 1) begin n_fail++; $display("FAIL shortsync_then_idle: pkt_start count %0d expected 1", c_start - s0); end
  endtask

`ifdef USB_FS_RX_BUS_RESET_DET_EN
  task automatic test_bus_reset();
    int r0, e0;
    r0 = c_err; e0 = c_end;
    send_sync();
    send_data(16'h0005, 3, 1'b0);
    {usb_n_rx, usb_p_rx} = SE0;
    repeat (122) @(posedge clk_48mhz);
    #1;
    n_chk++;
    if (bus_reset !== 1'b0) begin n_fail++; $display("FAIL busrst_early: got %b expected 0", bus_reset); end
    @(posedge clk_48mhz);
    #1;
    n_chk++;
    if (bus_reset !== 1'b1 || rx_active !== 1'b0) begin
      n_fail++;
      $display("FAIL busrst_assert: bus_reset %b rx_active %b expected 1 and 0", bus_reset, rx_active);
    end
    repeat (7) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    sym(LJ, 8);
    n_chk++;
    if (bus_reset !== 1'b0) begin n_fail++; $display("FAIL busrst_release: got %b expected 0", bus_reset); end
    n_chk++;
    if (c_err - r0 !== 0 || c_end - e0 !== 0) begin
      n_fail++;
      $display("FAIL busrst_no_err: err %0d end %0d expected 0 and 0", c_err - r0, c_end - e0);
    end
    sym(LJ, 16);
  endtask
`endif

  task automatic test_reset_midpacket();
    send_sync();
    send_data(16'h0005, 3, 1'b0);
    n_chk++;
    if (rx_active !== 1'b1) begin n_fail++; $display("FAIL midpkt_active: got %b expected 1", rx_active); end
    #3;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({line_state, pkt_start, bit_strobe, bit_data, pkt_end, rx_err, rx_active, bus_reset} !== 9'b01_0000000) begin
      n_fail++;
      $display("FAIL midpkt_reset: got %b expected %b",
               {line_state, pkt_start, bit_strobe, bit_data, pkt_end, rx_err, rx_active, bus_reset}, 9'b01_0000000);
    end
    {usb_n_rx, usb_p_rx} = LJ;
    @(negedge clk_48mhz);
    reset_n = 1'b1;
    sym(LJ, 16);
  endtask

  task automatic test_pulse_rules();
    n_chk++;
    if (c_multi !== 0) begin n_fail++; $display("FAIL pulse_exclusive: overlapping cycles %0d expected 0", c_multi); end
    n_chk++;
    if (min_gap < 3) begin n_fail++; $display("FAIL strobe_spacing: min gap %0d expected >= 3", min_gap); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_byte_a5();
    test_unstuff();
    test_stuff_err();
    test_jitter();
    test_short_sync();
`ifdef USB_FS_RX_BUS_RESET_DET_EN
    test_bus_reset();
`endif
    test_pulse_rules();
    test_reset_midpacket();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
